// File: rtl/checkpoint_mem_mover.sv
// Copies a memory region between the live area and checkpoint backing store
// for the checkpoint controller, using single-beat read/write requests.
module checkpoint_mem_mover #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_req,
  input  logic                  restore_req,
  input  logic [ADDR_WIDTH-1:0] ckpt_addr,
  input  logic [ADDR_WIDTH-1:0] live_addr,
  input  logic [31:0]           xfer_size,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_rvalid,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  input  logic                  wr_gnt,
  input  logic                  mem_err,
  output logic                  save_done,
  output logic                  restore_done,
  output logic                  xfer_error,
  output logic                  busy,
  output logic [31:0]           beats_done,
  output logic [2:0]            state_dbg
);

  localparam int BPB  = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BPB);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = CW + 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_XFER     = 3'd2;
  localparam logic [2:0] S_ABORT    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;
  localparam logic [2:0] S_WAIT_REL = 3'd6;

  logic [2:0]            state, state_nxt;
  logic                  is_restore;
  logic [ADDR_WIDTH-1:0] live_base, ckpt_base, src_base, dst_base;
  logic [31:0]           total_beats, rd_issued, beats_cnt;
  logic [CW-1:0]         outstanding, fifo_count;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic        in_xfer, req_live, rd_fire, wr_fire, rv_take, push, pop, last_write, flush;
  logic [32:0] size_round;

  // Handshake: a request (rd_req/wr_req) holds its address and data stable
  // until the matching grant is seen high on a rising edge; req&&gnt is one beat.
  assign in_xfer    = (state == S_XFER);
  assign req_live   = is_restore ? restore_req : save_req;
  assign rd_req     = in_xfer && (rd_issued < total_beats) &&
                      (SW'(outstanding) + SW'(fifo_count) < SW'(FIFO_DEPTH));
  assign wr_req     = in_xfer && (fifo_count != '0);
  assign rd_addr    = in_xfer ? src_base + (ADDR_WIDTH'(rd_issued) << OFFW) : '0;
  assign wr_addr    = in_xfer ? dst_base + (ADDR_WIDTH'(beats_cnt) << OFFW) : '0;
  assign wr_wdata   = wr_req ? fifo_mem[rd_ptr] : '0;
  assign rd_fire    = rd_req && rd_gnt;
  assign wr_fire    = wr_req && wr_gnt;
  // Returns with nothing outstanding are stray and dropped; outside XFER they are discarded.
  assign rv_take    = rd_rvalid && (outstanding != '0);
  assign push       = rv_take && in_xfer;
  assign pop        = wr_fire;
  assign last_write = wr_fire && (beats_cnt + 32'd1 == total_beats);
  assign flush      = (state == S_SETUP) || (state == S_ERR) || (state == S_ABORT);
  assign size_round = {1'b0, xfer_size} + 33'(BPB - 1);

  assign save_done    = (state == S_DONE) && !is_restore;
  assign restore_done = (state == S_DONE) && is_restore;
  assign xfer_error   = (state == S_ERR);
  assign busy         = (state != S_IDLE);
  assign beats_done   = beats_cnt;
  assign state_dbg    = state;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (save_req && restore_req)      state_nxt = S_ERR;
        else if (save_req || restore_req) state_nxt = S_SETUP;
      end
      S_SETUP:    state_nxt = (total_beats == 32'd0) ? S_DONE : S_XFER;
      S_XFER: begin
        if (last_write)    state_nxt = S_DONE;
        else if (mem_err)  state_nxt = S_ERR;
        else if (!req_live) state_nxt = S_ABORT;
      end
      S_ABORT:    if (outstanding == '0) state_nxt = S_IDLE;
      S_DONE:     state_nxt = S_WAIT_REL;
      S_ERR:      state_nxt = S_WAIT_REL;
      // Waiting for the level requests to drop keeps a held request from re-triggering.
      S_WAIT_REL: if (!save_req && !restore_req && outstanding == '0) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      is_restore  <= 1'b0;
      live_base   <= '0;
      ckpt_base   <= '0;
      src_base    <= '0;
      dst_base    <= '0;
      total_beats <= '0;
      rd_issued   <= '0;
      beats_cnt   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (save_req != restore_req)) begin
        is_restore  <= restore_req;
        live_base   <= live_addr & ALIGN_MASK;
        ckpt_base   <= ckpt_addr & ALIGN_MASK;
        total_beats <= 32'(size_round >> OFFW);
      end
      if (state == S_SETUP) begin
        src_base  <= is_restore ? ckpt_base : live_base;
        dst_base  <= is_restore ? live_base : ckpt_base;
        rd_issued <= '0;
        beats_cnt <= '0;
      end else begin
        if (rd_fire) rd_issued <= rd_issued + 32'd1;
        if (wr_fire) beats_cnt <= beats_cnt + 32'd1;
      end
      case ({rd_fire, rv_take})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (flush) begin
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_rdata;
  end

endmodule

// File: tb/tb_checkpoint_mem_mover.sv
// Bench for checkpoint_mem_mover: a randomized fabric model serves reads from an
// address-derived pattern and a scoreboard checks every read/write beat in order.
module tb_checkpoint_mem_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        save_req, restore_req;
  logic [63:0] ckpt_addr, live_addr;
  logic [31:0] xfer_size;
  logic        rd_req;
  logic [63:0] rd_addr;
  logic        rd_gnt, rd_rvalid;
  logic [63:0] rd_rdata;
  logic        wr_req;
  logic [63:0] wr_addr, wr_wdata;
  logic        wr_gnt, mem_err;
  logic        save_done, restore_done, xfer_error, busy;
  logic [31:0] beats_done;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // fabric knobs
  int rd_gnt_pct = 100, wr_gnt_pct = 100, lat_min = 1, lat_max = 1;
  int wr_block_until = 0, err_at = -1;
  bit err_fired;
  logic [63:0] seed;

  // scoreboard and observation state
  logic [63:0] exp_ra_q[$];
  logic [63:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];
  logic [63:0] pend_addr_q[$];
  int          pend_rdy_q[$];
  int n_rd_gnt, n_wr_gnt, max_infl, last_wr_gnt_cyc, first_rdreq_cyc;
  int n_save_done, n_restore_done, n_err, done_cyc, job_c0;

  checkpoint_mem_mover dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
    .ckpt_addr(ckpt_addr), .live_addr(live_addr), .xfer_size(xfer_size),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
    .rd_rdata(rd_rdata), .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .wr_gnt(wr_gnt), .mem_err(mem_err), .save_done(save_done),
    .restore_done(restore_done), .xfer_error(xfer_error), .busy(busy),
    .beats_done(beats_done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need end");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] data_of(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ seed;
  endfunction

  // Fabric model: drives grants/returns on the falling edge, scoreboards each beat.
  initial begin
    rd_gnt = 0; rd_rvalid = 0; rd_rdata = '0; wr_gnt = 0; mem_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr_q.delete(); pend_rdy_q.delete();
        rd_gnt = 0; rd_rvalid = 0; wr_gnt = 0; mem_err = 0;
        continue;
      end
      if (save_done)    begin n_save_done++;    done_cyc = cyc; end
      if (restore_done) begin n_restore_done++; done_cyc = cyc; end
      if (xfer_error)   n_err++;
      if (rd_req && first_rdreq_cyc < 0) first_rdreq_cyc = cyc;
      if (pend_addr_q.size() > 0 && pend_rdy_q[0] <= cyc) begin
        rd_rvalid = 1;
        rd_rdata  = data_of(pend_addr_q.pop_front());
        void'(pend_rdy_q.pop_front());
      end else begin
        rd_rvalid = 0;
        rd_rdata  = {$urandom, $urandom};
      end
      rd_gnt = rd_req && (int'($urandom_range(1, 100)) <= rd_gnt_pct);
      if (rd_gnt) begin
        int rdy;
        logic [63:0] ea;
        rdy = cyc + int'($urandom_range(lat_min, lat_max));
        if (pend_rdy_q.size() > 0 && rdy < pend_rdy_q[$]) rdy = pend_rdy_q[$];
        pend_addr_q.push_back(rd_addr);
        pend_rdy_q.push_back(rdy);
        n_rd_gnt++;
        total++;
        if (exp_ra_q.size() == 0) begin
          bad++;
          $display("FAIL rd_extra: got read at %h, need no read", rd_addr);
        end else begin
          ea = exp_ra_q.pop_front();
          if (rd_addr !== ea) begin
            bad++;
            $display("FAIL rd_addr: got %h, need %h", rd_addr, ea);
          end
        end
      end
      wr_gnt = wr_req && (cyc >= wr_block_until) && (int'($urandom_range(1, 100)) <= wr_gnt_pct);
      if (wr_gnt) begin
        logic [63:0] ea, ed;
        n_wr_gnt++;
        last_wr_gnt_cyc = cyc;
        total++;
        if (exp_wa_q.size() == 0) begin
          bad++;
          $display("FAIL wr_extra: got write at %h, need no write", wr_addr);
        end else begin
          ea = exp_wa_q.pop_front();
          ed = exp_wd_q.pop_front();
          if (wr_addr !== ea || wr_wdata !== ed) begin
            bad++;
            $display("FAIL wr_beat: got %h/%h, need %h/%h", wr_addr, wr_wdata, ea, ed);
          end
        end
      end
      if (n_rd_gnt - n_wr_gnt > max_infl) max_infl = n_rd_gnt - n_wr_gnt;
      mem_err = (err_at >= 0) && !err_fired && (n_wr_gnt == err_at);
      if (mem_err) err_fired = 1;
    end
  end

  // driver tasks; the reference model builds the expected beats from the job parameters
  task automatic start_job(input bit is_restore, input bit both, input logic [63:0] live,
                           input logic [63:0] ckpt, input logic [31:0] size);
    logic [63:0] src, dst, off, nb;
    @(negedge clk);
    exp_ra_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    n_rd_gnt = 0; n_wr_gnt = 0; max_infl = 0; last_wr_gnt_cyc = -1; first_rdreq_cyc = -1;
    n_save_done = 0; n_restore_done = 0; n_err = 0; done_cyc = -1; err_fired = 0;
    seed = {$urandom, $urandom};
    src = is_restore ? (ckpt & ~64'd7) : (live & ~64'd7);
    dst = is_restore ? (live & ~64'd7) : (ckpt & ~64'd7);
    nb  = ({32'd0, size} + 64'd7) / 64'd8;
    if (!both) begin
      for (int i = 0; i < int'(nb); i++) begin
        off = 64'(i) * 64'd8;
        exp_ra_q.push_back(src + off);
        exp_wa_q.push_back(dst + off);
        exp_wd_q.push_back(data_of(src + off));
      end
    end
    live_addr = live; ckpt_addr = ckpt; xfer_size = size;
    save_req = both || !is_restore;
    restore_req = both || is_restore;
    job_c0 = cyc;
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_save_done + n_restore_done + n_err > 0) begin ok = 1; break; end
    end
  endtask

  task automatic drop_idle(input int hold, input int budget, output bit ok,
                           output int lat, output bit pend_empty);
    repeat (hold) @(negedge clk);
    save_req = 0; restore_req = 0;
    ok = 0; lat = -1; pend_empty = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; lat = i; pend_empty = (pend_addr_q.size() == 0); break; end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    save_req = 0; restore_req = 0; ckpt_addr = '0; live_addr = '0; xfer_size = '0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rd_req, wr_req, save_done, restore_done, xfer_error, busy} !== 6'b0 ||
        beats_done !== 32'd0 || rd_addr !== 64'd0 || wr_addr !== 64'd0 || wr_wdata !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b beats=%0d, need all zero",
               {rd_req, wr_req, save_done, restore_done, xfer_error, busy}, beats_done);
    end
  endtask

  task automatic test_save_basic();
    bit ok, pe; int lat;
    rd_gnt_pct = 100; wr_gnt_pct = 100; lat_min = 1; lat_max = 1; wr_block_until = 0; err_at = -1;
    start_job(0, 0, 64'h1000, 64'h8000, 32);
    wait_pulse(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL save_basic_timeout: got no pulse, need save_done"); end
    drop_idle(10, 50, ok, lat, pe);
    total++;
    if (n_save_done != 1 || n_restore_done != 0 || n_err != 0) begin
      bad++;
      $display("FAIL save_basic_pulses: got s=%0d r=%0d e=%0d, need 1/0/0", n_save_done, n_restore_done, n_err);
    end
    total++;
    if (beats_done !== 32'd4 || exp_wa_q.size() != 0 || exp_ra_q.size() != 0) begin
      bad++;
      $display("FAIL save_basic_beats: got %0d left=%0d, need 4 left=0", beats_done, exp_wa_q.size());
    end
    total++;
    if (first_rdreq_cyc - job_c0 != 2) begin
      bad++;
      $display("FAIL save_basic_rd_latency: got %0d, need 2", first_rdreq_cyc - job_c0);
    end
    total++;
    if (done_cyc != last_wr_gnt_cyc + 1) begin
      bad++;
      $display("FAIL save_basic_done_latency: got %0d, need %0d", done_cyc, last_wr_gnt_cyc + 1);
    end
    total++;
    if (!ok || lat != 1) begin bad++; $display("FAIL save_basic_release: got lat=%0d, need 1", lat); end
  endtask

  task automatic test_restore_unaligned();
    bit ok, pe; int lat;
    start_job(1, 0, 64'h2000, 64'h8003, 20);
    wait_pulse(200, ok);
    drop_idle(2, 50, ok, lat, pe);
    total++;
    if (n_restore_done != 1 || n_save_done != 0 || n_err != 0 || n_wr_gnt != 3 || exp_wa_q.size() != 0) begin
      bad++;
      $display("FAIL restore_unaligned: got r=%0d s=%0d e=%0d wr=%0d, need 1/0/0/3",
               n_restore_done, n_save_done, n_err, n_wr_gnt);
    end
    total++;
    if (beats_done !== 32'd3) begin bad++; $display("FAIL restore_beats: got %0d, need 3", beats_done); end
  endtask

  task automatic test_size_zero();
    bit ok, pe; int lat;
    start_job(0, 0, 64'h1000, 64'h8000, 0);
    wait_pulse(20, ok);
    total++;
    if (!ok || done_cyc - job_c0 != 2) begin
      bad++;
      $display("FAIL size0_done_latency: got %0d, need 2", done_cyc - job_c0);
    end
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL size0_busy_held: got %b, need 1", busy); end
    drop_idle(0, 20, ok, lat, pe);
    total++;
    if (lat != 1 || n_rd_gnt != 0 || n_wr_gnt != 0 || first_rdreq_cyc != -1 || n_save_done != 1) begin
      bad++;
      $display("FAIL size0_traffic: got lat=%0d rd=%0d wr=%0d done=%0d, need 1/0/0/1",
               lat, n_rd_gnt, n_wr_gnt, n_save_done);
    end
  endtask

  task automatic test_wr_stall();
    bit ok, pe; int lat;
    wr_block_until = cyc + 21;
    start_job(0, 0, 64'h4000, 64'hC000, 128);
    wait_pulse(400, ok);
    drop_idle(1, 50, ok, lat, pe);
    total++;
    if (max_infl != 4) begin bad++; $display("FAIL stall_inflight: got %0d, need 4", max_infl); end
    total++;
    if (n_save_done != 1 || n_wr_gnt != 16 || exp_wa_q.size() != 0 || beats_done !== 32'd16) begin
      bad++;
      $display("FAIL stall_complete: got done=%0d wr=%0d beats=%0d, need 1/16/16", n_save_done, n_wr_gnt, beats_done);
    end
    wr_block_until = 0;
  endtask

  task automatic test_mem_err();
    bit ok, pe; int lat;
    lat_min = 10; lat_max = 12; err_at = 2;
    start_job(0, 0, 64'h1000, 64'h9000, 64);
    wait_pulse(300, ok);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL err_busy_held: got %b, need 1", busy); end
    drop_idle(0, 100, ok, lat, pe);
    total++;
    if (n_err != 1 || n_save_done != 0 || n_restore_done != 0) begin
      bad++;
      $display("FAIL err_pulses: got e=%0d s=%0d r=%0d, need 1/0/0", n_err, n_save_done, n_restore_done);
    end
    total++;
    if (n_wr_gnt != 2 || exp_wa_q.size() != 6) begin
      bad++;
      $display("FAIL err_writes: got %0d, need 2", n_wr_gnt);
    end
    total++;
    if (!ok || !pe) begin bad++; $display("FAIL err_release: got idle=%b pend_empty=%b, need 1/1", ok, pe); end
    lat_min = 1; lat_max = 1; err_at = -1;
  endtask

  task automatic test_abort();
    bit ok, pe;
    lat_min = 3; lat_max = 6; wr_gnt_pct = 60;
    start_job(0, 0, 64'h3000, 64'hA000, 128);
    for (int i = 0; i < 300 && n_wr_gnt < 3; i++) @(negedge clk);
    save_req = 0;
    @(negedge clk);
    total++;
    if (rd_req !== 1'b0 || wr_req !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet: got rd=%b wr=%b, need 0/0", rd_req, wr_req);
    end
    ok = 0; pe = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin ok = 1; pe = (pend_addr_q.size() == 0); break; end
      @(negedge clk);
    end
    total++;
    if (!ok || !pe || n_save_done + n_restore_done + n_err != 0) begin
      bad++;
      $display("FAIL abort_release: got idle=%b pend_empty=%b pulses=%0d, need 1/1/0",
               ok, pe, n_save_done + n_restore_done + n_err);
    end
    lat_min = 1; lat_max = 1; wr_gnt_pct = 100;
  endtask

  task automatic test_both_reqs();
    bit ok, pe; int lat;
    start_job(0, 1, 64'h1000, 64'h8000, 64);
    wait_pulse(20, ok);
    drop_idle(4, 20, ok, lat, pe);
    total++;
    if (n_err != 1 || n_save_done != 0 || n_restore_done != 0 || n_rd_gnt != 0 ||
        n_wr_gnt != 0 || first_rdreq_cyc != -1 || !ok) begin
      bad++;
      $display("FAIL both_reqs: got e=%0d s=%0d r=%0d rd=%0d wr=%0d, need 1/0/0/0/0",
               n_err, n_save_done, n_restore_done, n_rd_gnt, n_wr_gnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, pe; int lat;
    wr_gnt_pct = 50;
    start_job(1, 0, 64'h5000, 64'hD000, 128);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({rd_req, wr_req, save_done, restore_done, xfer_error, busy} !== 6'b0 ||
        beats_done !== 32'd0 || rd_addr !== 64'd0 || wr_addr !== 64'd0 || wr_wdata !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got ctl=%b beats=%0d, need all zero",
               {rd_req, wr_req, save_done, restore_done, xfer_error, busy}, beats_done);
    end
    save_req = 0; restore_req = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    wr_gnt_pct = 100;
    start_job(0, 0, 64'h6000, 64'hE000, 40);
    wait_pulse(200, ok);
    drop_idle(1, 50, ok, lat, pe);
    total++;
    if (n_save_done != 1 || n_err != 0 || exp_wa_q.size() != 0 || beats_done !== 32'd5) begin
      bad++;
      $display("FAIL reset_mid_fresh: got done=%0d err=%0d beats=%0d, need 1/0/5", n_save_done, n_err, beats_done);
    end
  endtask

  task automatic test_random();
    bit ok, pe, is_r; int lat; logic [63:0] live, ckpt; logic [31:0] size;
    for (int j = 0; j < 14; j++) begin
      rd_gnt_pct = int'($urandom_range(30, 100));
      wr_gnt_pct = int'($urandom_range(30, 100));
      lat_min = int'($urandom_range(1, 2));
      lat_max = lat_min + int'($urandom_range(0, 4));
      is_r = 1'($urandom_range(0, 1));
      live = {$urandom, $urandom};
      ckpt = {$urandom, $urandom};
      if (j == 0) live = 64'hFFFF_FFFF_FFFF_FFF3;
      size = 32'($urandom_range(0, 96));
      start_job(is_r, 0, live, ckpt, size);
      wait_pulse(1500, ok);
      drop_idle(int'($urandom_range(0, 3)), 100, ok, lat, pe);
      total++;
      if (!ok || n_err != 0 || n_save_done != (is_r ? 0 : 1) || n_restore_done != (is_r ? 1 : 0) ||
          exp_wa_q.size() != 0 || exp_ra_q.size() != 0 || beats_done !== (size + 32'd7) / 32'd8) begin
        bad++;
        $display("FAIL random_job%0d: got s=%0d r=%0d e=%0d left=%0d beats=%0d, need dir=%0d size=%0d",
                 j, n_save_done, n_restore_done, n_err, exp_wa_q.size(), beats_done, is_r, size);
      end
    end
    rd_gnt_pct = 100; wr_gnt_pct = 100; lat_min = 1; lat_max = 1;
  endtask

  initial begin
    test_reset();
    test_save_basic();
    test_restore_unaligned();
    test_size_zero();
    test_wr_stall();
    test_mem_err();
    test_abort();
    test_both_reqs();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
